// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC channel scheduler.
package adc_pkg;

  localparam int unsigned ADC_RAW_W  = 12;
  localparam int unsigned ADC_RES_W  = 8;
  localparam int unsigned ADC_CH_W   = 3;

  // Well-known channel assignments used by downstream consumers
  localparam logic [ADC_CH_W-1:0] ADC_CH_ACCEL = 3'd1;
  localparam logic [ADC_CH_W-1:0] ADC_CH_CDS   = 3'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADC_CH_W-1:0]  ch;
    logic [ADC_RES_W-1:0] data;
  } adc_rsp_t;

  // Keep the upper result bits of a raw conversion; plain truncation
  function automatic logic [ADC_RES_W-1:0] adc_trunc(input logic [ADC_RAW_W-1:0] raw);
    return raw[ADC_RAW_W-1 -: ADC_RES_W];
  endfunction

endpackage

// File: rtl/adc_channel_scheduler_rr_pick.sv
// Round-robin first-set-bit finder: lowest set bit at or after rr_ptr_i, wrapping.
module rr_pick
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH = 8
) (
  input  logic [NUM_CH-1:0]   pending_i,
  input  logic [ADC_CH_W-1:0] rr_ptr_i,
  output logic [ADC_CH_W-1:0] grant_o,
  output logic                any_o
);

  // Scan from the farthest offset down so the nearest set bit wins
  always_comb begin
    logic [ADC_CH_W-1:0] idx;
    idx     = '0;
    grant_o = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      idx = ADC_CH_W'((int'(rr_ptr_i) + i) % NUM_CH);
      if (pending_i[idx]) grant_o = idx;
    end
  end

  assign any_o = |pending_i;

endmodule

// File: rtl/adc_channel_scheduler.sv
// Shares one SPI ADC engine between a periodic auto-scan and host requests.
// Optional macro ADC_SCHED_AVG_EN enables a 3:1 IIR smoothing of stored results.
module adc_channel_scheduler
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             scan_mask,
  input  logic                          req_valid,
  input  logic [ADC_CH_W-1:0]           req_ch,
  output logic                          req_ready,
  output logic                          conv_start,
  output logic [ADC_CH_W-1:0]           conv_ch,
  input  logic                          conv_busy,
  input  logic                          conv_done,
  input  logic [ADC_RAW_W-1:0]          conv_data,
  output logic [ADC_RES_W*NUM_CH-1:0]   ch_result,
  output logic [NUM_CH-1:0]             ch_valid,
  output logic                          rsp_valid,
  output logic [ADC_CH_W-1:0]           rsp_ch,
  output logic [ADC_RES_W-1:0]          rsp_data,
  output logic                          timeout_err
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  state_e                            state_q, state_d;
  logic [SCAN_W-1:0]                 scan_cnt_q, scan_cnt_d;
  logic [TO_W-1:0]                   to_cnt_q, to_cnt_d;
  logic [NUM_CH-1:0]                 pending_q, pending_d;
  logic [NUM_CH-1:0]                 host_q, host_d;
  logic [NUM_CH-1:0]                 defer_pend_q, defer_pend_d;
  logic [NUM_CH-1:0]                 defer_host_q, defer_host_d;
  logic [ADC_CH_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [ADC_CH_W-1:0]               conv_ch_q, conv_ch_d;
  logic                              conv_start_q, conv_start_d;
  logic [ADC_RES_W-1:0]              sample_q, sample_d;
  logic [NUM_CH-1:0][ADC_RES_W-1:0]  res_q, res_d;
  logic [NUM_CH-1:0]                 ch_valid_q, ch_valid_d;
  logic                              rsp_valid_q, rsp_valid_d;
  adc_rsp_t                          rsp_q, rsp_d;
  logic                              timeout_err_q, timeout_err_d;

  logic                  scan_tick, ch_ok, accept, to_hit, any, clr_en, store_en;
  logic [ADC_CH_W-1:0]   grant;
  logic [NUM_CH-1:0]     req_oh, clr_oh, inflight_oh, set_pend, set_host;
  logic [ADC_RES_W-1:0]  store_val;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (grant),
    .any_o     (any)
  );

  // Request acceptance; out-of-range channels are accepted and dropped
  assign ch_ok     = int'(req_ch) < NUM_CH;
  assign req_oh    = ch_ok ? (NUM_CH'(1) << req_ch) : '0;
  assign req_ready = rst & ~(|(req_oh & pending_q & host_q));
  assign accept    = req_valid & req_ready & ch_ok;
  assign scan_tick = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign to_hit    = (to_cnt_q == TO_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any && !conv_busy) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (conv_done)   state_d = STORE;
        else if (to_hit) state_d = IDLE;
      end
      STORE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: engine handshake, timeout tracking, clear/store strobes
  always_comb begin
    conv_start_d  = 1'b0;
    conv_ch_d     = conv_ch_q;
    to_cnt_d      = to_cnt_q;
    sample_d      = sample_q;
    timeout_err_d = timeout_err_q;
    clr_en        = 1'b0;
    store_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any && !conv_busy) begin
          conv_start_d = 1'b1;
          conv_ch_d    = grant;
        end
      end
      ISSUE: to_cnt_d = '0;
      WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (conv_done) begin
          sample_d = adc_trunc(conv_data);
        end else if (to_hit) begin
          timeout_err_d = 1'b1;
          clr_en        = 1'b1;
        end
      end
      STORE: begin
        store_en = 1'b1;
        clr_en   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ADC_SCHED_AVG_EN
  // 3:1 smoothing against the previous stored value; first sample taken as-is
  logic [ADC_RES_W-1:0] old_val;
  logic [9:0]           avg_sum;
  assign old_val   = res_q[conv_ch_q];
  assign avg_sum   = 10'(3) * 10'(old_val) + 10'(sample_q) + 10'd2;
  assign store_val = ch_valid_q[conv_ch_q] ? avg_sum[9:2] : sample_q;
`else
  assign store_val = sample_q;
`endif

  // Pending/host bookkeeping and result storage; sets hitting the in-flight
  // channel are deferred until it returns to IDLE so they are never lost
  always_comb begin
    inflight_oh  = (state_q != IDLE) ? (NUM_CH'(1) << conv_ch_q) : '0;
    clr_oh       = clr_en ? (NUM_CH'(1) << conv_ch_q) : '0;
    set_pend     = (scan_tick ? scan_mask : '0) | (accept ? req_oh : '0);
    set_host     = accept ? req_oh : '0;
    pending_d    = ((pending_q | (set_pend & ~inflight_oh)) & ~clr_oh)
                 | ((state_q == IDLE) ? defer_pend_q : '0);
    host_d       = ((host_q | (set_host & ~inflight_oh)) & ~clr_oh)
                 | ((state_q == IDLE) ? defer_host_q : '0);
    defer_pend_d = ((state_q == IDLE) ? '0 : defer_pend_q) | (set_pend & inflight_oh);
    defer_host_d = ((state_q == IDLE) ? '0 : defer_host_q) | (set_host & inflight_oh);
    rr_ptr_d     = clr_en ? ADC_CH_W'((int'(conv_ch_q) + 1) % NUM_CH) : rr_ptr_q;
    scan_cnt_d   = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
    res_d        = res_q;
    ch_valid_d   = ch_valid_q;
    rsp_valid_d  = 1'b0;
    rsp_d        = rsp_q;
    if (store_en) begin
      res_d[conv_ch_q]      = store_val;
      ch_valid_d[conv_ch_q] = 1'b1;
      if (host_q[conv_ch_q]) begin
        rsp_valid_d = 1'b1;
        rsp_d.ch    = conv_ch_q;
        rsp_d.data  = store_val;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q    <= '0;
      to_cnt_q      <= '0;
      pending_q     <= '0;
      host_q        <= '0;
      defer_pend_q  <= '0;
      defer_host_q  <= '0;
      rr_ptr_q      <= '0;
      conv_ch_q     <= '0;
      conv_start_q  <= 1'b0;
      sample_q      <= '0;
      res_q         <= '0;
      ch_valid_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      to_cnt_q      <= to_cnt_d;
      pending_q     <= pending_d;
      host_q        <= host_d;
      defer_pend_q  <= defer_pend_d;
      defer_host_q  <= defer_host_d;
      rr_ptr_q      <= rr_ptr_d;
      conv_ch_q     <= conv_ch_d;
      conv_start_q  <= conv_start_d;
      sample_q      <= sample_d;
      res_q         <= res_d;
      ch_valid_q    <= ch_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_q         <= rsp_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign conv_start  = conv_start_q;
  assign conv_ch     = conv_ch_q;
  assign ch_result   = res_q;
  assign ch_valid    = ch_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_ch      = rsp_q.ch;
  assign rsp_data    = rsp_q.data;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler with a simple engine model.
module tb_adc_channel_scheduler;

  logic        clk;
  logic        rst;
  logic [7:0]  scan_mask;
  logic        req_valid;
  logic [2:0]  req_ch;
  logic        req_ready;
  logic        conv_start;
  logic [2:0]  conv_ch;
  logic        conv_busy;
  logic        conv_done;
  logic [11:0] conv_data;
  logic [63:0] ch_result;
  logic [7:0]  ch_valid;
  logic        rsp_valid;
  logic [2:0]  rsp_ch;
  logic [7:0]  rsp_data;
  logic        timeout_err;

  logic        eng_busy;
  logic        force_busy;
  logic        eng_en;
  logic [11:0] eng_data [8];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rph      = 0;

  logic [2:0] start_hist[$];
  int         last_start_cyc = 0;
  logic [2:0] last_start_ch  = 3'd0;
  int         last_done_cyc  = 0;
  int         rsp_cnt        = 0;
  int         last_rsp_cyc   = 0;
  logic [2:0] last_rsp_ch    = 3'd0;
  logic [7:0] last_rsp_data  = 8'd0;

  assign conv_busy = eng_busy | force_busy;

  adc_channel_scheduler #(.NUM_CH(8), .SCAN_DIV(100), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_mask   (scan_mask),
    .req_valid   (req_valid),
    .req_ch      (req_ch),
    .req_ready   (req_ready),
    .conv_start  (conv_start),
    .conv_ch     (conv_ch),
    .conv_busy   (conv_busy),
    .conv_done   (conv_done),
    .conv_data   (conv_data),
    .ch_result   (ch_result),
    .ch_valid    (ch_valid),
    .rsp_valid   (rsp_valid),
    .rsp_ch      (rsp_ch),
    .rsp_data    (rsp_data),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (conv_start) begin
      start_hist.push_back(conv_ch);
      last_start_cyc = cyc;
      last_start_ch  = conv_ch;
    end
    if (conv_done) last_done_cyc = cyc;
    if (rsp_valid) begin
      rsp_cnt++;
      last_rsp_cyc  = cyc;
      last_rsp_ch   = rsp_ch;
      last_rsp_data = rsp_data;
    end
  end

  // Engine model: busy for three cycles after a start, then a one-cycle done
  initial begin
    logic [2:0] ch;
    eng_busy  = 1'b0;
    conv_done = 1'b0;
    conv_data = 12'h000;
    forever begin
      @(posedge clk); #1;
      if (conv_start && eng_en) begin
        ch       = conv_ch;
        eng_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        conv_data = eng_data[ch];
        conv_done = 1'b1;
        eng_busy  = 1'b0;
        @(posedge clk); #1;
        conv_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_starts(input int target, input int budget);
    for (int b = 0; b < budget && start_hist.size() < target; b++) tick();
  endtask

  task automatic wait_rsps(input int target, input int budget);
    for (int b = 0; b < budget && rsp_cnt < target; b++) tick();
  endtask

  task automatic request(input logic [2:0] ch);
    req_ch    = ch;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  function automatic logic [3:0] hist(input int i);
    if (i < start_hist.size()) return {1'b0, start_hist[i]};
    return 4'hF;
  endfunction

  initial begin
    int acc, s0, rb, sc;
    logic [7:0] avg2;
    rst = 1'b1; req_valid = 1'b0; req_ch = 3'd0; scan_mask = 8'h00;
    force_busy = 1'b0; eng_en = 1'b1;
    for (int i = 0; i < 8; i++) eng_data[i] = 12'h000;
    eng_data[0] = 12'hAB0; eng_data[1] = 12'h5F0; eng_data[2] = 12'h123;
    eng_data[3] = 12'h3C5; eng_data[5] = 12'hFFF; eng_data[6] = 12'h660;
    eng_data[7] = 12'h770;
    #2 rst = 1'b0;
    run(3);

    // Reset state
    check("rst_conv_start", conv_start, 0);
    check("rst_conv_ch", conv_ch, 0);
    check("rst_ch_valid", ch_valid, 0);
    check("rst_ch_result", ch_result, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_req_ready", req_ready, 0);
    rst = 1'b1; rph = cyc;
    tick();

    // Host request ch5 on an idle scheduler
    req_ch = 3'd5; req_valid = 1'b1; acc = cyc; s0 = start_hist.size(); rb = rsp_cnt;
    check("t1_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("t1_req_ready_dup", req_ready, 0);
    wait_starts(s0 + 1, 10);
    check("t1_start_cnt", start_hist.size() - s0, 1);
    check("t1_start_lat", last_start_cyc - acc, 2);
    check("t1_conv_ch", last_start_ch, 5);
    wait_rsps(rb + 1, 30);
    check("t1_rsp_cnt", rsp_cnt - rb, 1);
    check("t1_rsp_ch", last_rsp_ch, 5);
    check("t1_rsp_data", last_rsp_data, 8'hFF);
    check("t1_rsp_lat", last_rsp_cyc - last_done_cyc, 2);
    check("t1_ch_valid", ch_valid, 8'h20);
    check("t1_result5", ch_result[47:40], 8'hFF);

    // Auto-scan of ch0 and ch1
    s0 = start_hist.size(); rb = rsp_cnt;
    scan_mask = 8'h03;
    wait_starts(s0 + 2, 250);
    scan_mask = 8'h00;
    run(30);
    check("t2_first", hist(s0), 0);
    check("t2_second", hist(s0 + 1), 1);
    check("t2_result0", ch_result[7:0], 8'hAB);
    check("t2_result1", ch_result[15:8], 8'h5F);
    check("t2_ch_valid", ch_valid, 8'h23);
    check("t2_no_rsp", rsp_cnt - rb, 0);

    // Round-robin: serve ch6 so the pointer lands on 7, then pend 7,2,6
    rb = rsp_cnt;
    request(3'd6);
    wait_rsps(rb + 1, 30);
    force_busy = 1'b1;
    tick();
    request(3'd7);
    request(3'd2);
    request(3'd6);
    req_ch = 3'd7; req_valid = 1'b1;
    check("t3_req_ready_pend", req_ready, 0);
    tick();
    req_valid = 1'b0;
    s0 = start_hist.size(); rb = rsp_cnt;
    force_busy = 1'b0;
    wait_starts(s0 + 3, 80);
    wait_rsps(rb + 3, 40);
    check("t3_grant0", hist(s0), 7);
    check("t3_grant1", hist(s0 + 1), 2);
    check("t3_grant2", hist(s0 + 2), 6);
    check("t3_rsp_cnt", rsp_cnt - rb, 3);

    // Host request for ch3 in the same cycle as a scan tick with bit3 set
    for (int b = 0; b < 250 && ((cyc - rph) % 100) != 99; b++) tick();
    s0 = start_hist.size(); rb = rsp_cnt;
    req_ch = 3'd3; req_valid = 1'b1; scan_mask = 8'h08;
    tick();
    req_valid = 1'b0; scan_mask = 8'h00;
    run(40);
    check("t4_start_cnt", start_hist.size() - s0, 1);
    check("t4_conv_ch", last_start_ch, 3);
    check("t4_rsp_cnt", rsp_cnt - rb, 1);
    check("t4_rsp_ch", last_rsp_ch, 3);
    check("t4_rsp_data", last_rsp_data, 8'h3C);

    // Engine timeout on ch4, ch1 queued behind it is still served
    eng_en = 1'b0;
    s0 = start_hist.size(); rb = rsp_cnt;
    request(3'd4);
    wait_starts(s0 + 1, 10);
    sc = last_start_cyc;
    eng_en = 1'b1;
    request(3'd1);
    for (int b = 0; b < 40 && cyc < sc + 16; b++) tick();
    check("t5_to_early", timeout_err, 0);
    tick();
    check("t5_to_set", timeout_err, 1);
    wait_rsps(rb + 1, 30);
    check("t5_rsp_cnt", rsp_cnt - rb, 1);
    check("t5_rsp_ch", last_rsp_ch, 1);
    check("t5_rsp_data", last_rsp_data, 8'h5F);
    check("t5_no_result4", ch_valid[4], 0);
    check("t5_sticky", timeout_err, 1);

    // Asynchronous reset while waiting on the engine
    s0 = start_hist.size();
    request(3'd2);
    wait_starts(s0 + 1, 10);
    tick();
    check("t6_pre_conv_ch", conv_ch, 2);
    rst = 1'b0;
    #1;
    check("t6_conv_start", conv_start, 0);
    check("t6_conv_ch", conv_ch, 0);
    check("t6_ch_valid", ch_valid, 0);
    check("t6_ch_result", ch_result, 0);
    check("t6_timeout_err", timeout_err, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_req_ready", req_ready, 0);
    tick();
    rst = 1'b1; rph = cyc;
    s0 = start_hist.size(); rb = rsp_cnt;
    run(20);
    check("t6_no_stale_start", start_hist.size() - s0, 0);
    check("t6_no_stale_rsp", rsp_cnt - rb, 0);

    // Two samples on ch0: 0x80 then 0x00
`ifdef ADC_SCHED_AVG_EN
    avg2 = 8'h60;
`else
    avg2 = 8'h00;
`endif
    eng_data[0] = 12'h800;
    rb = rsp_cnt;
    request(3'd0);
    wait_rsps(rb + 1, 30);
    check("t7_first", last_rsp_data, 8'h80);
    eng_data[0] = 12'h000;
    tick();
    request(3'd0);
    wait_rsps(rb + 2, 30);
    check("t7_second", last_rsp_data, avg2);
    check("t7_result0", ch_result[7:0], avg2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_channel_scheduler.md
Name: adc_channel_scheduler

Overview:
- Sequences and shares a single-transaction SPI ADC engine (8-channel, 12-bit converter) between a periodic auto-scan and on-demand host requests.
- Keeps a pending bitmap per channel and arbitrates round-robin.
- Issues one conversion at a time over a start/busy/done handshake and stores per-channel 8-bit results.
- Sits between the SPI transaction engine and consumers such as the accelerator pedal and CDS light logic.

Parameters:
- NUM_CH, 8, number of ADC channels (power of 2, max 8).
- SCAN_DIV, 50000, clk cycles between auto-scan ticks.
- TIMEOUT, 4096, clk cycles allowed from conv_start to conv_done before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- scan_mask  in  NUM_CH  channels auto-converted on each scan tick.
- req_valid  in  1  host conversion request.
- req_ch  in  3  requested channel.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- conv_start  out  1  one-cycle pulse to the engine.
- conv_ch  out  3  channel for the engine, stable from conv_start until conv_done.
- conv_busy  in  1  engine busy.
- conv_done  in  1  one-cycle pulse, conv_data valid.
- conv_data  in  12  raw conversion result.
- ch_result  out  8*NUM_CH  per-channel result; channel k occupies bits [8k+7:8k].
- ch_valid  out  NUM_CH  channel has at least one stored result.
- rsp_valid  out  1  one-cycle pulse when a host-requested conversion completes.
- rsp_ch  out  3  channel of the rsp_valid response.
- rsp_data  out  8  result of the rsp_valid response.
- timeout_err  out  1  sticky; set on engine timeout, cleared only by reset.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; pending, host_tag, rr_ptr, scan counter and timeout counter all 0; state IDLE.
- Scan counter counts 0..SCAN_DIV-1. On wrap: pending |= scan_mask.
- req_ready = 1 unless pending[req_ch] & host_tag[req_ch] is already set.
  - On accept: pending[req_ch] = 1 and host_tag[req_ch] = 1.
  - req_ch >= NUM_CH: accepted and dropped, no response.
- A scan tick and a host accept in the same cycle merge by OR; host_tag is kept.
- FSM:
  - IDLE: if pending != 0 and !conv_busy, pick the first set bit at or after rr_ptr (wrapping); latch it into conv_ch. -> ISSUE.
  - ISSUE: conv_start = 1 for exactly one cycle; clear the timeout counter. -> WAIT.
  - WAIT: on conv_done, latch conv_data[11:4]. -> STORE. If the timeout counter reaches TIMEOUT-1 first: set timeout_err, clear pending[conv_ch] and host_tag[conv_ch], rr_ptr = conv_ch+1, no result update. -> IDLE.
  - STORE: write ch_result[conv_ch] and set ch_valid[conv_ch]. If host_tag[conv_ch] is set, pulse rsp_valid with rsp_ch and rsp_data. Clear pending[conv_ch] and host_tag[conv_ch]; rr_ptr = conv_ch+1 mod NUM_CH. -> IDLE.
- A new request for a channel whose conversion is in flight sets pending again after STORE's clear. Clear has priority only for the same-cycle collision; a same-cycle accept re-sets the bit next cycle, so the request is never lost.
- Latency: request accepted in IDLE with nothing else pending gives conv_start 2 cycles later. rsp_valid comes 2 cycles after conv_done.
- conv_done outside WAIT is ignored.
- Worst-case starvation bound: NUM_CH-1 conversions ahead.
- Truncation conv_data[11:4] is fixed; there is no rounding.

Optional Feature:
- Macro ADC_SCHED_AVG_EN.
- Defined: STORE writes ch_result = (3*old + new + 2) >> 2, computed in 10 bits, where new = conv_data[11:4]. The first sample after reset (ch_valid=0) is written directly. rsp_data carries the averaged value.
- Undefined: ch_result = conv_data[11:4] directly.

Decomposition:
- Shared package adc_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, STORE);
  - ADC_RAW_W=12 and ADC_RES_W=8;
  - the channel index width;
  - channel constants ADC_CH_ACCEL=1 and ADC_CH_CDS=0.
- One sub-module, rr_pick: combinational round-robin first-set-bit finder (inputs pending and rr_ptr; outputs grant index and any).

Test Plan:
- scan_mask=8'b0000_0011, SCAN_DIV=100, engine model returns 12'hAB0 on ch0 and 12'h5F0 on ch1 -> conversions issued in order ch0 then ch1. ch_result[0]=8'hAB, ch_result[1]=8'h5F, ch_valid=2'b11, rsp_valid never pulses.
- Idle scheduler, req_ch=5, conv_data=12'hFFF -> conv_start 2 cycles after accept with conv_ch=5. rsp_valid pulse with rsp_ch=5, rsp_data=8'hFF.
- Pending bits 2, 6 and 7 with rr_ptr=7 -> grant order 7, 2, 6.
- Engine never asserts conv_done, TIMEOUT=16 -> timeout_err=1 after 16 cycles in WAIT. FSM returns to IDLE and the next pending channel is still served.
- Host request for ch3 in the same cycle as a scan tick with mask bit3 set -> a single conversion, with rsp_valid.
- rst driven low during WAIT -> all outputs 0 immediately (asynchronous). After release, no stale conv_start.
- With ADC_SCHED_AVG_EN: samples 0x80 then 0x00 -> results 0x80 then 0x60.
